ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
PS/2 keyboard receiver that sits directly upstream of the keyboard matrix block. It deglitches the PS/2 clock and data lines and deserialises 11-bit device frames. It strips the E0/F0/E1 prefix bytes and emits one strobe per make or break event, carrying a scan code, a pressed flag and an extended flag. The code, strobe and pressed outputs connect directly to the matrix block's inputs of the same names.

Parameters:
FILTER, 8, consecutive identical system-clock samples required before the filtered PS/2 clock level changes (min 2).
TIMEOUT, 16384, system-clock cycles without a filtered PS/2 clock edge before a partial frame is aborted.

Ports:
clock  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-low; clears all state.
ps2ck  in  1  raw PS/2 clock from pad, asynchronous.
ps2d   in  1  raw PS/2 data from pad, asynchronous.
code   out 8  last scan code, prefix bytes stripped.
strobe out 1  one-cycle pulse, asserted when code/pressed/extended are newly valid.
pressed  out 1  1 = make, 0 = break (F0 seen).
extended out 1  1 = code was preceded by E0.
error  out 1  one-cycle pulse on framing error, parity error or timeout.

Behaviour:
- Reset (async assert, sync release): code=00, strobe=0, pressed=0, extended=0, error=0. State IDLE. ext/brk flags and skip count = 0. Sync flops, filtered clock and filter counter preset to line idle level 1.
- Input conditioning: both lines pass through 2-flop synchronisers. The filtered clock toggles only after FILTER consecutive samples differ from its current level; any matching sample restarts the count. A sample event is a filtered 1->0 transition; the synchronised ps2d is captured in that cycle. Data is not filtered.
- Frame FSM, advancing one state per sample event:
  - IDLE: on d=0 go to DATA with bitcnt=0; on d=1 stay.
  - DATA: shift d into bit 7, shifting right (LSB first). After the 8th bit go to PARITY.
  - PARITY: store d, go to STOP.
  - STOP: frame is valid if d=1 and XOR(data[7:0], parity)=1 (odd parity). Otherwise pulse error. Either way go to IDLE.
- Timeout: the counter clears on every filtered clock edge and increments otherwise, saturating. If not in IDLE and the count reaches TIMEOUT-1: go to IDLE, pulse error, clear ext/brk.
- On a valid byte, evaluated in the cycle after the STOP sample event:
  - skip>0: decrement skip; no strobe.
  - E1: skip=7, clear ext/brk. This swallows the rest of the 8-byte Pause sequence.
  - E0: set ext. F0: set brk. No strobe for either.
  - AA, FA, FE, EE, 00, FF (BAT/ack/resend/echo/overrun): clear ext/brk, no strobe.
  - Otherwise: code<=byte, pressed<=~brk, extended<=ext, strobe=1 for exactly one cycle, then clear ext/brk.
- Output timing: code/pressed/extended hold until the next strobe. Latency is 1 clock from the STOP sample event to strobe.
- Exclusivity: strobe and error never assert in the same cycle.
- Error side effects: an error does not alter code/pressed/extended.
- Prefix lifetime: ext/brk persist across frames until consumed by a strobe or cleared by error, timeout or reset.
- Width rules: bitcnt is 3 bits, skip is 3 bits, timeout counter is clog2(TIMEOUT) bits.
- Reset mid-frame: returns to IDLE immediately. The next start bit begins a fresh frame; no strobe for the partial frame.

Test Plan:
1. Frame 16 (start 0, data 0x16 LSB first, parity 0, stop 1) -> single strobe with code=16, pressed=1, extended=0; error stays 0.
2. Frames F0, 16 -> exactly one strobe with code=16, pressed=0, extended=0. Then frames E0, 75 -> strobe code=75, pressed=1, extended=1. Then E0, F0, 75 -> strobe code=75, pressed=0, extended=1.
3. Frame 1E with parity bit flipped -> error pulse, no strobe, code unchanged. Following good frame 1E -> strobe code=1E, pressed=1.
4. Stop PS/2 clock after 5 data bits for TIMEOUT+10 cycles -> one error pulse, FSM back in IDLE. Next full frame 29 -> strobe code=29.
5. Full Pause sequence E1 14 77 E1 F0 14 F0 77, then frame 5A -> no strobe for the first 8 bytes, one strobe code=5A, pressed=1. Frames AA and FA -> no strobe.
6. Clock glitches of FILTER-1 cycles injected mid-frame -> byte 4D decoded correctly. Reset asserted after 3 data bits, then a full frame 45 -> strobe code=45, no error.

Source files
------------

// File: rtl/ps2_keyboard_if.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_if
// Key-event bus from the PS/2 receiver to the keyboard matrix block.
//   code     [7:0] last scan code, prefix bytes stripped
//   strobe         one-cycle pulse: code/pressed/extended newly valid
//   pressed        1 = make, 0 = break
//   extended       1 = code was preceded by E0
//   error          one-cycle pulse on framing, parity or timeout error
// master: the receiver (drives everything); slave: the consumer.
// ---------------------------------------------------------------------------
interface ps2_keyboard_if;
  logic [7:0] code;
  logic       strobe;
  logic       pressed;
  logic       extended;
  logic       error;

  modport master (output code, strobe, pressed, extended, error);
  modport slave  (input  code, strobe, pressed, extended, error);
endinterface

// File: rtl/ps2_keyboard.sv
// ---------------------------------------------------------------------------
// ps2_keyboard
// PS/2 keyboard receiver. Synchronises and deglitches the pad clock,
// deserialises 11-bit device frames (start, 8 data LSB first, odd parity,
// stop), strips E0/F0/E1 prefixes and emits one strobe per make/break event.
//
// Parameters:
//   FILTER   consecutive differing samples before the filtered clock flips
//   TIMEOUT  idle cycles (no filtered clock edge) before a partial frame aborts
// Ports:
//   clock    system clock, posedge
//   reset    asynchronous active-low reset
//   ps2ck    raw PS/2 clock from pad (asynchronous)
//   ps2d     raw PS/2 data from pad (asynchronous)
//   kbd      key-event bus (master side)
// ---------------------------------------------------------------------------
module ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 16384
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ps2ck,
  input  logic           ps2d,
  ps2_keyboard_if.master kbd
);

  localparam int FW = $clog2(FILTER);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]    ck_sync, d_sync;
  logic          ck_s, d_s;
  logic          ck_filt, ck_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall, edge_any;

  assign ck_s = ck_sync[1];
  assign d_s  = d_sync[1];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync   <= 2'b11;
      d_sync    <= 2'b11;
      ck_filt   <= 1'b1;
      ck_filt_d <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      ck_sync   <= {ck_sync[0], ps2ck};
      d_sync    <= {d_sync[0], ps2d};
      ck_filt_d <= ck_filt;
      // Any sample matching the current level restarts the run length.
      if (ck_s != ck_filt) begin
        if (filt_cnt == FILT_MAX) begin
          ck_filt  <= ck_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall     = ck_filt_d & ~ck_filt;
  assign edge_any = ck_filt_d ^ ck_filt;

  // ---------------- timeout counter ----------------
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (edge_any) begin
      to_cnt <= '0;
    end else if (to_cnt != '1) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // ---------------- frame FSM ----------------
  state_t     state_q, state_n;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       frame_ok, frame_bad, timeout_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_n   = state_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    // A clock edge in this cycle means the line is alive; never time out then.
    timeout_hit = (state_q != IDLE) && !edge_any && (to_cnt == TO_LIMIT);
    unique case (state_q)
      IDLE:   if (fall && !d_s) state_n = DATA;
      DATA:   if (fall && bitcnt == 3'd7) state_n = PARITY;
      PARITY: if (fall) state_n = STOP;
      STOP: begin
        if (fall) begin
          if (d_s && (^shreg ^ par_bit)) frame_ok  = 1'b1;
          else                           frame_bad = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout_hit) state_n = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (fall) begin
      unique case (state_q)
        IDLE:   bitcnt <= '0;
        DATA: begin
          shreg  <= {d_s, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
        end
        PARITY: par_bit <= d_s;
        default: ;
      endcase
    end
  end

  // ---------------- byte decode / outputs ----------------
  logic [7:0] code_q;
  logic       strobe_q, pressed_q, extended_q, error_q;
  logic       ext, brk;
  logic [2:0] skip;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_q     <= '0;
      strobe_q   <= 1'b0;
      pressed_q  <= 1'b0;
      extended_q <= 1'b0;
      error_q    <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      skip       <= '0;
    end else begin
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      if (frame_bad || timeout_hit) begin
        error_q <= 1'b1;
        ext     <= 1'b0;
        brk     <= 1'b0;
      end else if (frame_ok) begin
        if (skip != 3'd0) begin
          // Swallowing the tail of a Pause sequence.
          skip <= skip - 3'd1;
        end else begin
          unique case (shreg)
            8'hE1: begin
              skip <= 3'd7;
              ext  <= 1'b0;
              brk  <= 1'b0;
            end
            8'hE0: ext <= 1'b1;
            8'hF0: brk <= 1'b1;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
              ext <= 1'b0;
              brk <= 1'b0;
            end
            default: begin
              code_q     <= shreg;
              pressed_q  <= ~brk;
              extended_q <= ext;
              strobe_q   <= 1'b1;
              ext        <= 1'b0;
              brk        <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign kbd.code     = code_q;
  assign kbd.strobe   = strobe_q;
  assign kbd.pressed  = pressed_q;
  assign kbd.extended = extended_q;
  assign kbd.error    = error_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard
// Drives PS/2 frames into ps2_keyboard. Expected strobe/error events are
// queued as stimulus is issued; a monitor on the falling system clock edge
// pops and compares each event the DUT presents.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 16384;
  localparam int HALF    = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ps2ck = 1'b1;
  logic ps2d  = 1'b1;

  ps2_keyboard_if kbd_if ();

  ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .ps2ck (ps2ck),
    .ps2d  (ps2d),
    .kbd   (kbd_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic       pressed;
    logic       extended;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Model of the held output values.
  logic [7:0] m_code     = 8'h00;
  logic       m_pressed  = 1'b0;
  logic       m_extended = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic expect_strobe(input logic [7:0] c, input logic p, input logic e);
    exp_t x;
    x.is_err = 1'b0; x.code = c; x.pressed = p; x.extended = e;
    exp_q.push_back(x);
    m_code = c; m_pressed = p; m_extended = e;
  endtask

  task automatic expect_error();
    exp_t x;
    x.is_err = 1'b1; x.code = m_code; x.pressed = m_pressed; x.extended = m_extended;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends the first nbits of a frame; optional parity flip and glitches
  // of FILTER-1 cycles in both clock phases of every bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input int nbits = 11, input bit glitch = 1'b0);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      cyc(HALF);
      ps2ck = 1'b0;
      if (glitch) begin
        cyc(HALF / 2);
        ps2ck = 1'b1;
        cyc(FILTER - 1);
        ps2ck = 1'b0;
        cyc(HALF / 2);
      end else begin
        cyc(HALF);
      end
      ps2ck = 1'b1;
      if (glitch) begin
        cyc(4);
        ps2ck = 1'b0;
        cyc(FILTER - 1);
        ps2ck = 1'b1;
      end
    end
    ps2d = 1'b1;
    cyc(HALF);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      cyc(1);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: every strobe or error must match the head of the queue.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && (kbd_if.strobe || kbd_if.error)) begin
      if (kbd_if.strobe && kbd_if.error)
        check("strobe_error_overlap", {kbd_if.strobe, kbd_if.error}, 2'b10);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {kbd_if.strobe, kbd_if.error}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {kbd_if.strobe, kbd_if.error}, e.is_err ? 2'b01 : 2'b10);
        check("code",     kbd_if.code,     e.code);
        check("pressed",  kbd_if.pressed,  e.pressed);
        check("extended", kbd_if.extended, e.extended);
      end
    end
  end

  initial begin
    // Reset state
    cyc(5);
    check("rst_code",     kbd_if.code,     8'h00);
    check("rst_strobe",   kbd_if.strobe,   1'b0);
    check("rst_pressed",  kbd_if.pressed,  1'b0);
    check("rst_extended", kbd_if.extended, 1'b0);
    check("rst_error",    kbd_if.error,    1'b0);
    reset = 1'b1;
    cyc(20);

    // 1: plain make
    expect_strobe(8'h16, 1'b1, 1'b0);
    send_frame(8'h16);
    drain("make_16");

    // 2: break, extended make, extended break
    send_frame(8'hF0);
    expect_strobe(8'h16, 1'b0, 1'b0);
    send_frame(8'h16);
    send_frame(8'hE0);
    expect_strobe(8'h75, 1'b1, 1'b1);
    send_frame(8'h75);
    send_frame(8'hE0);
    send_frame(8'hF0);
    expect_strobe(8'h75, 1'b0, 1'b1);
    send_frame(8'h75);
    drain("prefixes");

    // 3: parity error, then recovery
    expect_error();
    send_frame(8'h1E, 1'b1);
    drain("parity_err");
    expect_strobe(8'h1E, 1'b1, 1'b0);
    send_frame(8'h1E);
    drain("after_parity");

    // 4: timeout after 5 data bits
    expect_error();
    send_frame(8'h3C, 1'b0, 6);
    cyc(TIMEOUT + 10);
    drain("timeout");
    expect_strobe(8'h29, 1'b1, 1'b0);
    send_frame(8'h29);
    drain("after_timeout");

    // 5: Pause sequence swallowed, then control bytes ignored
    send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
    send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
    expect_strobe(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A);
    send_frame(8'hAA);
    send_frame(8'hFA);
    // AA clears a pending break prefix
    send_frame(8'hF0);
    send_frame(8'hAA);
    expect_strobe(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C);
    drain("pause_ctrl");

    // 6: glitches rejected; reset mid-frame
    expect_strobe(8'h4D, 1'b1, 1'b0);
    send_frame(8'h4D, 1'b0, 11, 1'b1);
    drain("glitch");
    send_frame(8'h45, 1'b0, 4);
    reset = 1'b0;
    cyc(3);
    check("midrst_code",     kbd_if.code,     8'h00);
    check("midrst_pressed",  kbd_if.pressed,  1'b0);
    check("midrst_extended", kbd_if.extended, 1'b0);
    reset = 1'b1;
    m_code = 8'h00; m_pressed = 1'b0; m_extended = 1'b0;
    cyc(10);
    expect_strobe(8'h45, 1'b1, 1'b0);
    send_frame(8'h45);
    drain("after_midrst");

    cyc(200);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
